// File: rtl/fb_arb_pkg.sv
// Shared constants, FSM states and read-tag type for the framebuffer port arbiter.
package fb_arb_pkg;

    localparam int H_RES      = 320;
    localparam int V_RES      = 240;
    localparam int FRAME_PIX  = H_RES * V_RES;
    localparam int PIX_W      = 8;
    localparam int ADDR_W     = 17;
    localparam int FIFO_DEPTH = 8;
    localparam int LOW_WM     = 4;
    localparam int RD_LAT     = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2,
        ST_DRAIN  = 2'd3
    } arb_state_e;

    // One slot of the read-tracking shift register.
    typedef struct packed {
        logic vld;
        logic sop;
        logic eop;
    } rd_tag_t;

endpackage

// File: rtl/fb_stream_fifo.sv
// Synchronous FIFO holding returned pixels with their sop/eop tags.
module fb_stream_fifo
    import fb_arb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int W     = PIX_W + 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    // Upstream bounds the fill level, so push never meets a full FIFO.
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign pop_data = store[rd_ptr];

    // Storage array needs no reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= push_data;
    end

    // Pointer and occupancy tracking; push+pop together leaves count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares one single-port framebuffer RAM between the Sobel writer and the
// VGA stream reader. Reader gets priority while the stream buffer runs low.
module fb_port_arbiter #(
    parameter int H_RES      = fb_arb_pkg::H_RES,
    parameter int V_RES      = fb_arb_pkg::V_RES,
    parameter int PIX_W      = fb_arb_pkg::PIX_W,
    parameter int ADDR_W     = fb_arb_pkg::ADDR_W,
    parameter int FIFO_DEPTH = fb_arb_pkg::FIFO_DEPTH,
    parameter int LOW_WM     = fb_arb_pkg::LOW_WM
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              en,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [23:0]       st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop
);

    import fb_arb_pkg::*;

    localparam int                FRAME     = H_RES * V_RES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME - 1);
    localparam int                CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int                LVL_W     = $clog2(FIFO_DEPTH + RD_LAT + 2);
    localparam int                FW        = PIX_W + 2;

    arb_state_e             state, state_nxt;
    logic [ADDR_W-1:0]      rd_addr;
    rd_tag_t [RD_LAT:0]     rd_pipe;
    logic [CNT_W-1:0]       fifo_cnt;
    logic                   fifo_empty;
    logic [FW-1:0]          fifo_q;
    logic [LVL_W-1:0]       in_flight;
    logic [LVL_W-1:0]       level;
    logic                   rd_elig;
    logic                   rd_gnt;
    logic                   wr_gnt;
    logic                   rd_last;

    // Slot 0 is the cycle mem_re is on the port; data returns with slot RD_LAT.
    // Every occupied slot is counted so granted reads always have FIFO room.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i <= RD_LAT; i++)
            in_flight = in_flight + LVL_W'(rd_pipe[i].vld);
        level = LVL_W'(fifo_cnt) + in_flight;
    end

    // Arbitration: starving reader first, then writer, then reader to fill up.
    always_comb begin
        rd_last = (rd_addr == LAST_ADDR);
        rd_elig = ((state == ST_RUN) || (state == ST_FINISH)) &&
                  (level < LVL_W'(FIFO_DEPTH));
        rd_gnt  = rd_elig && ((level < LVL_W'(LOW_WM)) || !wr_req);
        wr_gnt  = wr_req && !rd_gnt;
    end

    assign wr_ack = wr_gnt && reset_reset_n;

    // FSM state register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state <= ST_IDLE;
        else                state <= state_nxt;
    end

    // Next-state: a frame only ends early-stop on its last address.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (en) state_nxt = ST_RUN;
            ST_RUN:    if (!en) state_nxt = (rd_gnt && rd_last) ? ST_DRAIN : ST_FINISH;
            ST_FINISH: begin
                if (en)                  state_nxt = ST_RUN;
                else if (rd_gnt && rd_last) state_nxt = ST_DRAIN;
            end
            ST_DRAIN:  if (level == '0) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Frame read address, wrapping at the last pixel.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)  rd_addr <= '0;
        else if (rd_gnt)     rd_addr <= rd_last ? '0 : rd_addr + 1'b1;
    end

    // Registered RAM port plus the read-tag shift register behind it.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            rd_pipe   <= '0;
        end else begin
            mem_we     <= wr_gnt;
            rd_pipe[0] <= '{vld: rd_gnt,
                            sop: rd_gnt && (rd_addr == '0),
                            eop: rd_gnt && rd_last};
            for (int i = 1; i <= RD_LAT; i++)
                rd_pipe[i] <= rd_pipe[i-1];
            if (wr_gnt) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end else if (rd_gnt) begin
                mem_addr  <= rd_addr;
            end
        end
    end

    assign mem_re = rd_pipe[0].vld;

    fb_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .push      (rd_pipe[RD_LAT].vld),
        .push_data ({rd_pipe[RD_LAT].sop, rd_pipe[RD_LAT].eop, mem_rdata}),
        .pop       (st_valid && st_ready),
        .pop_data  (fifo_q),
        .count     (fifo_cnt),
        .empty     (fifo_empty)
    );

    // Stream outputs are forced to zero whenever nothing is buffered.
    always_comb begin
        st_valid = !fifo_empty;
        st_data  = st_valid ? {3{fifo_q[PIX_W-1:0]}} : 24'd0;
        st_sop   = st_valid && fifo_q[PIX_W+1];
        st_eop   = st_valid && fifo_q[PIX_W];
    end

endmodule
